// File: rtl/mat_pkg.sv
// Shared layout for the flattened 3x3 matrix element stream. The ALU, this
// transmitter and the receiving packer all use the same element ordering.
package mat_pkg;

  localparam int ELEM_W   = 32;
  localparam int DIM      = 3;
  localparam int NUM_ELEM = DIM * DIM;
  localparam int MAT_W    = NUM_ELEM * ELEM_W;
  localparam int IDX_W    = 4;

  localparam logic [IDX_W-1:0] DET_IDX       = IDX_W'(9);
  localparam logic [IDX_W-1:0] LAST_ELEM_IDX = IDX_W'(NUM_ELEM - 1);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  // Row-major element idx; E00 occupies the most significant word.
  // Indices outside 0..NUM_ELEM-1 yield zero.
  function automatic logic [ELEM_W-1:0] elem_at(
    input logic [MAT_W-1:0] mat,
    input logic [IDX_W-1:0] idx
  );
    logic [ELEM_W-1:0] res;
    res = '0;
    for (int i = 0; i < NUM_ELEM; i++) begin
      if (idx == IDX_W'(i)) res = mat[MAT_W-1-i*ELEM_W -: ELEM_W];
    end
    return res;
  endfunction

endpackage

// File: rtl/mat_elem_mux.sv
// Beat selector: one of the nine matrix elements, or the determinant word at
// DET_IDX. Purely combinational so the FSM only deals with indices.
module mat_elem_mux
  import mat_pkg::*;
(
  input  logic [MAT_W-1:0]  mat,
  input  logic [ELEM_W-1:0] det,
  input  logic [IDX_W-1:0]  idx,
  output logic [ELEM_W-1:0] data
);

  always_comb begin
    // NOTE: data gets an unconditional value first so every idx path assigns it and no latch is inferred.
    data = elem_at(mat, idx);
    if (idx == DET_IDX) data = det;
  end

endmodule

// File: rtl/mat_stream_tx.sv
// Serialises a captured 3x3 matrix (plus optional determinant) onto a 32-bit
// valid/ready element stream, one element per accepted beat.
module mat_stream_tx
  import mat_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [MAT_W-1:0]  mat_in,
  input  logic [ELEM_W-1:0] det_in,
  input  logic              det_en,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [ELEM_W-1:0] tx_data,
  output logic [IDX_W-1:0]  tx_idx,
  output logic              tx_last,
  output logic              tx_is_det,
  output logic              busy
);

  state_t            state;
  logic [MAT_W-1:0]  shadow_mat;
  logic [ELEM_W-1:0] shadow_det;
  logic              shadow_det_en;

  // Selection for the beat that will be presented after the next edge. In
  // IDLE it looks straight at the load inputs so beat 0 is ready one cycle
  // after acceptance; in SEND it walks the shadow copy.
  logic [MAT_W-1:0]  sel_mat;
  logic [ELEM_W-1:0] sel_det;
  logic              sel_det_en;
  logic [IDX_W-1:0]  next_idx;
  logic [ELEM_W-1:0] next_data;
  logic              next_last;

  always_comb begin
    sel_mat    = shadow_mat;
    sel_det    = shadow_det;
    sel_det_en = shadow_det_en;
    next_idx   = tx_idx + IDX_W'(1);
    if (state == IDLE) begin
      sel_mat    = mat_in;
      sel_det    = det_in;
      sel_det_en = det_en;
      next_idx   = '0;
    end
    next_last = (next_idx == DET_IDX) ||
                ((next_idx == LAST_ELEM_IDX) && !sel_det_en);
  end

  mat_elem_mux u_elem_mux (
    .mat  (sel_mat),
    .det  (sel_det),
    .idx  (next_idx),
    .data (next_data)
  );

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      // NOTE: the shadow capture registers are reset too, so an abandoned transfer leaves no stale data behind.
      shadow_mat    <= '0;
      shadow_det    <= '0;
      shadow_det_en <= 1'b0;
      tx_valid      <= 1'b0;
      tx_data       <= '0;
      tx_idx        <= '0;
      tx_last       <= 1'b0;
      tx_is_det     <= 1'b0;
      busy          <= 1'b0;
      load_ready    <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (load_valid) begin
            state         <= SEND;
            shadow_mat    <= mat_in;
            shadow_det    <= det_in;
            shadow_det_en <= det_en;
            tx_valid      <= 1'b1;
            tx_idx        <= next_idx;
            tx_data       <= next_data;
            tx_last       <= next_last;
            tx_is_det     <= (next_idx == DET_IDX);
            busy          <= 1'b1;
            load_ready    <= 1'b0;
          end
        end
        SEND: begin
          if (tx_ready) begin
            if (tx_last) begin
              state      <= IDLE;
              tx_valid   <= 1'b0;
              tx_data    <= '0;
              tx_idx     <= '0;
              tx_last    <= 1'b0;
              tx_is_det  <= 1'b0;
              busy       <= 1'b0;
              load_ready <= 1'b1;
            end else begin
              tx_idx     <= next_idx;
              tx_data    <= next_data;
              tx_last    <= next_last;
              tx_is_det  <= (next_idx == DET_IDX);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Structural invariants of the stream.
  a_idx_range : assert property (@(posedge clk) disable iff (reset)
    tx_idx <= DET_IDX);
  a_busy_send : assert property (@(posedge clk) disable iff (reset)
    (busy == (state == SEND)) && (tx_valid == busy) && (load_ready == !busy));

endmodule

// File: tb/tb_mat_stream_tx.sv
// Self-checking bench for mat_stream_tx: directed scenarios plus randomized
// transfers compared against a beat-list model built from the matrix layout.
module tb_mat_stream_tx;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  idx;
    logic        last;
    logic        is_det;
  } beat_t;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         load_valid = 1'b0;
  logic         load_ready;
  logic [287:0] mat_in = '0;
  logic [31:0]  det_in = '0;
  logic         det_en = 1'b0;
  logic         tx_valid;
  logic         tx_ready = 1'b0;
  logic [31:0]  tx_data;
  logic [3:0]   tx_idx;
  logic         tx_last;
  logic         tx_is_det;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] elems [9];
  logic [31:0] det_val;
  logic        den_val;
  beat_t       exp_q [$];
  beat_t       got_q [$];

  mat_stream_tx dut (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .mat_in     (mat_in),
    .det_in     (det_in),
    .det_en     (det_en),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_data    (tx_data),
    .tx_idx     (tx_idx),
    .tx_last    (tx_last),
    .tx_is_det  (tx_is_det),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Model: the transfer is the nine elements in row-major order, then the
  // determinant if enabled; the final beat carries last.
  task automatic build_expected();
    beat_t b;
    exp_q.delete();
    for (int i = 0; i < 9; i++) begin
      b.data = elems[i]; b.idx = 4'(i);
      b.last = (i == 8) && !den_val; b.is_det = 1'b0;
      exp_q.push_back(b);
    end
    if (den_val) begin
      b.data = det_val; b.idx = 4'd9; b.last = 1'b1; b.is_det = 1'b1;
      exp_q.push_back(b);
    end
  endtask

  task automatic set_seq(input logic [31:0] base);
    for (int i = 0; i < 9; i++) elems[i] = base + 32'(i);
  endtask

  task automatic step_cycle();
    if (tx_valid === 1'b1 && tx_ready === 1'b1)
      got_q.push_back({tx_data, tx_idx, tx_last, tx_is_det});
    @(posedge clk);
    #1;
  endtask

  task automatic apply_load();
    for (int i = 0; i < 9; i++) mat_in[287-i*32 -: 32] = elems[i];
    det_in     = det_val;
    det_en     = den_val;
    load_valid = 1'b1;
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    mat_in     = {9{$urandom()}};
  endtask

  task automatic run_stream(input bit rand_ready, output int cycles, output bit to);
    bit done;
    cycles = 0;
    to = 1'b1;
    for (int k = 0; k < 400; k++) begin
      tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      done = (tx_valid === 1'b1) && tx_ready && (tx_last === 1'b1);
      step_cycle();
      cycles++;
      if (done) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic wait_idx(input logic [3:0] target, output bit to);
    tx_ready = 1'b1;
    to = 1'b1;
    for (int k = 0; k < 50; k++) begin
      if (tx_valid === 1'b1 && tx_idx === target) begin
        to = 1'b0;
        break;
      end
      step_cycle();
    end
  endtask

  task automatic test_reset();
    #2;
    reset = 1'b1;
    #1;
    n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", tx_valid); end
    n_checks++; if (tx_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", tx_data); end
    n_checks++; if (tx_idx !== 4'h0) begin n_fail++; $display("FAIL reset_idx: got %0d want 0", tx_idx); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (load_ready !== 1'b1) begin n_fail++; $display("FAIL reset_load_ready: got %b want 1", load_ready); end
    n_checks++; if ({tx_last, tx_is_det} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b want 00", {tx_last, tx_is_det}); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_stream();
    int cyc; bit to;
    set_seq(32'd1); det_val = 32'h1234_5678; den_val = 1'b0;
    build_expected(); got_q.delete();
    apply_load();
    run_stream(1'b0, cyc, to);
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL basic_timeout: stream did not end"); end
    n_checks++; if (cyc !== 9) begin n_fail++; $display("FAIL basic_cycles: got %0d want 9", cyc); end
    n_checks++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL basic_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL basic_beat%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL basic_gap_valid: got %b want 0", tx_valid); end
    n_checks++; if (load_ready !== 1'b1) begin n_fail++; $display("FAIL basic_gap_ready: got %b want 1", load_ready); end
  endtask

  task automatic test_det_beat();
    int cyc; bit to;
    set_seq(32'd1); det_val = 32'hFFFF_FFFD; den_val = 1'b1;
    build_expected(); got_q.delete();
    apply_load();
    run_stream(1'b0, cyc, to);
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL det_timeout: stream did not end"); end
    n_checks++; if (cyc !== 10) begin n_fail++; $display("FAIL det_cycles: got %0d want 10", cyc); end
    n_checks++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL det_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL det_beat%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL det_gap_busy: got %b want 0", busy); end
  endtask

  task automatic test_backpressure();
    int cyc; bit to;
    bit pat [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    set_seq(32'd1); det_val = 32'h0; den_val = 1'b0;
    build_expected(); got_q.delete();
    apply_load();
    wait_idx(4'd3, to);
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL bp_reach: idx 3 never presented"); end
    tx_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step_cycle();
      n_checks++;
      if ({tx_valid, tx_data, tx_idx, tx_last, tx_is_det} !== {1'b1, 32'd4, 4'd3, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL bp_hold%0d: got valid=%b data=%h idx=%0d last=%b det=%b want 1/4/3/0/0",
                 k, tx_valid, tx_data, tx_idx, tx_last, tx_is_det);
      end
    end
    for (int k = 0; k < 4; k++) begin
      tx_ready = pat[k];
      step_cycle();
    end
    n_checks++; if (tx_idx !== 4'd5) begin n_fail++; $display("FAIL bp_toggle_idx: got %0d want 5", tx_idx); end
    run_stream(1'b0, cyc, to);
    n_checks++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL bp_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_beat%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_load_during_send();
    int cyc; bit to;
    set_seq(32'd1); det_val = 32'h0; den_val = 1'b0;
    build_expected(); got_q.delete();
    apply_load();
    wait_idx(4'd4, to);
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL lds_reach: idx 4 never presented"); end
    mat_in = {9{32'hDEAD_BEEF}}; det_in = 32'hDEAD_BEEF; det_en = 1'b1;
    load_valid = 1'b1;
    step_cycle();
    load_valid = 1'b0;
    run_stream(1'b0, cyc, to);
    n_checks++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL lds_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL lds_beat%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    step_cycle();
    n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL lds_no_pending: got valid %b want 0", tx_valid); end
    for (int i = 0; i < 9; i++) elems[i] = 32'hDEAD_BEEF;
    build_expected(); got_q.delete();
    apply_load();
    run_stream(1'b0, cyc, to);
    n_checks++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL lds_new_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL lds_new_beat%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int cyc; bit to;
    for (int i = 0; i < 9; i++) elems[i] = $urandom();
    det_val = $urandom(); den_val = 1'b1;
    apply_load();
    wait_idx(4'd5, to);
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL rmid_reach: idx 5 never presented"); end
    #2;
    reset = 1'b1;
    #1;
    n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %b want 0", tx_valid); end
    n_checks++; if (load_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL rmid_ctrl: got ready=%b busy=%b want 1/0", load_ready, busy); end
    @(posedge clk); #1;
    reset = 1'b0;
    step_cycle();
    n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_no_resume: got valid %b want 0", tx_valid); end
    set_seq(32'd10); det_val = 32'h0; den_val = 1'b0;
    build_expected(); got_q.delete();
    apply_load();
    n_checks++; if (tx_idx !== 4'd0 || tx_data !== 32'd10) begin n_fail++; $display("FAIL rmid_restart: got idx=%0d data=%h want 0/a", tx_idx, tx_data); end
    run_stream(1'b0, cyc, to);
    n_checks++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL rmid_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rmid_beat%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    int cyc; bit to;
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < 9; i++) elems[i] = $urandom();
      det_val = $urandom(); den_val = 1'($urandom_range(0, 1));
      build_expected(); got_q.delete();
      for (int g = $urandom_range(0, 3); g > 0; g--) begin
        tx_ready = 1'($urandom_range(0, 1));
        step_cycle();
      end
      apply_load();
      run_stream(1'b1, cyc, to);
      n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL rand%0d_timeout: stream did not end", t); end
      n_checks++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL rand%0d_count: got %0d want %0d", t, got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand%0d_beat%0d: got %h want %h", t, i, got_q[i], exp_q[i]); end
      end
      n_checks++; if (tx_valid !== 1'b0 || load_ready !== 1'b1) begin n_fail++; $display("FAIL rand%0d_gap: got valid=%b ready=%b want 0/1", t, tx_valid, load_ready); end
    end
  endtask

  initial begin
    test_reset();
    test_basic_stream();
    test_det_beat();
    test_backpressure();
    test_load_during_send();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mat_stream_tx.md
Name: mat_stream_tx

Overview:
Transmitter that serialises a flattened 3x3 integer matrix, plus an optional determinant word, onto a 32-bit valid/ready element stream. It sits downstream of the matrix ALU: it captures MatrixOut/determinant-style results in one cycle and emits them one element per accepted beat toward a narrow consumer (UART/bus bridge, result FIFO). It is the sending end of the element stream whose receiving end packs 9 words back into a 288-bit matrix.

Parameters:
ELEM_W, 32, width of one matrix element and of the determinant, two's-complement integer
DIM, 3, rows = columns; NUM_ELEM = DIM*DIM = 9, MAT_W = NUM_ELEM*ELEM_W = 288

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high
load_valid  in  1  producer offers mat_in/det_in/det_en
load_ready  out  1  block can accept a load; high only in IDLE
mat_in  in  MAT_W  row-major matrix; E[r][c] at bits [MAT_W-1-(r*DIM+c)*ELEM_W -: ELEM_W], so E00=[287:256], E22=[31:0]
det_in  in  ELEM_W  determinant word, sent after the matrix when det_en=1
det_en  in  1  append determinant beat to this transfer
tx_valid  out  1  tx_data/tx_idx/tx_last/tx_is_det valid
tx_ready  in  1  consumer accepts current beat
tx_data  out  ELEM_W  current element or determinant
tx_idx  out  4  beat index: 0..8 element (r*DIM+c), 9 determinant
tx_last  out  1  final beat of transfer
tx_is_det  out  1  current beat is the determinant
busy  out  1  transfer in progress (state SEND)

Behaviour:
- Reset is asynchronous: clk and reset clock a single always block; no synchronous clear path. While reset is asserted: state=IDLE, tx_valid=0, tx_data=0, tx_idx=0, tx_last=0, tx_is_det=0, busy=0, load_ready=1, and the capture registers are cleared. An in-flight transfer is abandoned, with no partial completion after release.
- States: IDLE, SEND.
- IDLE: load_ready=1, tx_valid=0. On a rising edge with load_valid=1, capture mat_in, det_in and det_en into shadow registers, set idx=0, and go to SEND.
- Latency: a load accepted at edge N presents tx_valid=1, tx_idx=0 and tx_data=E00 from edge N onward, so the first beat is available in the cycle after acceptance.
- SEND: load_ready=0, busy=1, tx_valid=1. tx_data is the shadow element idx, or det for idx 9.
- A beat transfers on an edge where tx_valid and tx_ready are both 1; idx then increments.
- While tx_ready=0, tx_data, tx_idx, tx_last and tx_is_det hold stable. The consumer may hold tx_ready high continuously, giving one beat per cycle.
- tx_last is 1 when idx=8 with det_en=0, or when idx=9 with det_en=1. tx_is_det is 1 only at idx=9.
- When the last beat transfers, go to IDLE. The next cycle shows tx_valid=0 and load_ready=1, so back-to-back transfers have a minimum one-cycle gap.
- load_valid during SEND is ignored and leaves the shadow registers untouched. mat_in may change freely after capture.
- No arithmetic is performed. Data passes bit-exact; sign is not interpreted.
- idx never exceeds 9. Wrap back to 0 happens only via IDLE.

Decomposition:
- Package mat_pkg:
  - ELEM_W, DIM, NUM_ELEM, MAT_W, IDX_W=4, DET_IDX=9
  - state enum {IDLE, SEND}
  - a function returning the element slice for a given index; the ALU and the receiver reuse the same layout
- Sub-module mat_elem_mux: combinational 9:1 (+det) element selector from shadow matrix and idx. Keeps the FSM block free of slicing logic.

Test Plan:
1. Reset: assert reset asynchronously between clock edges, in IDLE -> tx_valid=0, tx_data=0, tx_idx=0, busy=0, load_ready=1 immediately, without waiting for a clock edge.
2. Basic stream: mat_in with E00..E22 = 1..9, det_en=0, tx_ready held 1 -> tx_data 1,2,...,9 on 9 consecutive cycles, tx_idx 0..8, tx_last only with data 9, tx_is_det never 1; the following cycle shows tx_valid=0, load_ready=1.
3. Determinant beat: same matrix, det_en=1, det_in=32'hFFFFFFFD -> 10 beats; beat 10 has tx_idx=9, tx_is_det=1, tx_last=1, tx_data=FFFFFFFD; beat 9 (data 9) has tx_last=0.
4. Backpressure: tx_ready=0 for 5 cycles while tx_idx=3 -> tx_data stays 4 and tx_idx stays 3, tx_valid stays 1. Then tx_ready toggles 1,0,1,0 -> exactly one beat per high cycle; the stream completes in order with no duplicates or skips.
5. Load during SEND: pulse load_valid with all elements = 32'hDEADBEEF at tx_idx=4 -> pulse ignored, remaining beats are 5..9; the new load is accepted only once back in IDLE.
6. Reset mid-transfer: assert reset at tx_idx=5 -> tx_valid drops immediately. After release, load a matrix with elements 10..18 -> stream restarts at tx_idx=0, tx_data=10.
